// File: rtl/nios_sysid_checker_pkg.sv
// Shared types and constants for the Nios sysid checker: FSM states, slave
// word offsets and default expected values.
package nios_sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FIN
  } state_t;

  localparam logic ID_OFS = 1'b0;
  localparam logic TS_OFS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID    = 32'd291;
  localparam logic [31:0] DEF_EXPECTED_TS    = 32'd1435585823;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/nios_sysid_checker_tmo.sv
// Per-transaction cycle counter; o_expired flags the last permitted cycle
// that passes without a capture.
module nios_sysid_checker_tmo
  import nios_sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fires when this uncaptured cycle would bring the count to TIMEOUT_CYCLES.
  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/nios_sysid_checker.sv
// Reads the sysid slave (ID then timestamp) over Avalon-MM and compares
// both words against the expected build values, with a per-read timeout.
module nios_sysid_checker
  import nios_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic        av_readdatavalid,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_start_ok;
  logic        w_clear;
  logic        w_enable;
  logic        w_expired;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  assign w_accept   = av_read && !av_waitrequest;
  // Data is taken in the accept cycle itself or in any later WAIT cycle.
  assign w_cap_id   = ((r_state == ID_REQ) && w_accept && av_readdatavalid) ||
                      ((r_state == ID_WAIT) && av_readdatavalid);
  assign w_cap_ts   = ((r_state == TS_REQ) && w_accept && av_readdatavalid) ||
                      ((r_state == TS_WAIT) && av_readdatavalid);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == FIN));
  assign w_enable   = busy && !w_cap_id && !w_cap_ts;
  assign w_clear    = ((w_next == ID_REQ) && (r_state != ID_REQ)) ||
                      ((w_next == TS_REQ) && (r_state != TS_REQ));

  nios_sysid_checker_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_clear   (w_clear),
    .i_enable  (w_enable),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, FIN: if (w_start_ok) w_next = ID_REQ;
      ID_REQ: begin
        if (w_cap_id)       w_next = TS_REQ;
        else if (w_expired) w_next = FIN;
        else if (w_accept)  w_next = ID_WAIT;
      end
      ID_WAIT: begin
        if (w_cap_id)       w_next = TS_REQ;
        else if (w_expired) w_next = FIN;
      end
      TS_REQ: begin
        if (w_cap_ts)       w_next = FIN;
        else if (w_expired) w_next = FIN;
        else if (w_accept)  w_next = TS_WAIT;
      end
      TS_WAIT: begin
        if (w_cap_ts || w_expired) w_next = FIN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    av_read    = (r_state == ID_REQ) || (r_state == TS_REQ);
    av_address = ((r_state == TS_REQ) || (r_state == TS_WAIT)) ? TS_OFS : ID_OFS;
    busy       = (r_state == ID_REQ) || (r_state == ID_WAIT) ||
                 (r_state == TS_REQ) || (r_state == TS_WAIT);
    done       = (r_state == FIN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      if (w_start_ok) begin
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_cap_id) begin
        r_id_value <= av_readdata;
        r_id_ok    <= (av_readdata == EXPECTED_ID);
      end
      if (w_cap_ts) begin
        r_ts_value <= av_readdata;
        r_ts_ok    <= (av_readdata == EXPECTED_TS);
      end
      if (w_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Directed and randomized check of nios_sysid_checker against a reactive
// sysid slave and a transaction-level outcome model.
module tb_nios_sysid_checker;
  import nios_sysid_checker_pkg::*;

  localparam int unsigned  T   = 10;
  localparam logic [31:0]  EID = DEF_EXPECTED_ID;
  localparam logic [31:0]  ETS = DEF_EXPECTED_TS;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic        av_readdatavalid;
  logic [31:0] av_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  always #5 clock = ~clock;

  nios_sysid_checker #(
    .EXPECTED_ID   (EID),
    .EXPECTED_TS   (ETS),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .av_address      (av_address),
    .av_read         (av_read),
    .av_waitrequest  (av_waitrequest),
    .av_readdatavalid(av_readdatavalid),
    .av_readdata     (av_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slave behaviour per word (index 0 = ID, 1 = timestamp).
  int          cfg_wait[2];
  int          cfg_lat[2];
  logic [31:0] cfg_data[2];
  bit          cfg_never[2];

  bit s_in_req, s_pend;
  int s_wcnt, s_lcnt, s_idx, accepts;

  logic [31:0] m_id, m_ts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge: sets slave inputs for the coming rising edge.
  task automatic slave_drive();
    int a;
    av_waitrequest   = 1'b1;
    av_readdatavalid = 1'b0;
    av_readdata      = $urandom;
    if (!busy && $urandom_range(0, 3) == 0) av_readdatavalid = 1'b1;
    if (s_pend) begin
      if (s_lcnt == 0) begin
        av_readdatavalid = 1'b1;
        av_readdata      = cfg_data[s_idx];
        s_pend           = 1'b0;
      end else begin
        s_lcnt--;
      end
    end
    if (!av_read) begin
      s_in_req = 1'b0;
    end else begin
      a = av_address ? 1 : 0;
      if (!s_in_req) begin
        s_in_req = 1'b1;
        s_wcnt   = 0;
      end
      if (s_wcnt < cfg_wait[a]) begin
        s_wcnt++;
        if ($urandom_range(0, 3) == 0) av_readdatavalid = 1'b1;
      end else begin
        av_waitrequest = 1'b0;
        accepts++;
        s_in_req = 1'b0;
        if (!cfg_never[a]) begin
          if (cfg_lat[a] == 0) begin
            av_readdatavalid = 1'b1;
            av_readdata      = cfg_data[a];
          end else begin
            s_pend = 1'b1;
            s_lcnt = cfg_lat[a] - 1;
            s_idx  = a;
          end
        end
      end
    end
  endtask

  task automatic run_seq(input int w0, input int l0, input logic [31:0] d0, input bit n0,
                         input int w1, input int l1, input logic [31:0] d1, input bit n1,
                         input bit noisy);
    bit to0, to1;
    int cyc, acc, bcnt;
    cfg_wait  = '{w0, w1};
    cfg_lat   = '{l0, l1};
    cfg_data  = '{d0, d1};
    cfg_never = '{n0, n1};
    s_pend = 1'b0; s_in_req = 1'b0; accepts = 0;

    // Outcome model: a read completes w+1+l cycles after its request starts.
    to0 = n0 || (w0 + 1 + l0 > int'(T));
    to1 = !to0 && (n1 || (w1 + 1 + l1 > int'(T)));
    cyc = to0 ? int'(T) : (w0 + 1 + l0) + (to1 ? int'(T) : (w1 + 1 + l1));
    acc = ((w0 + 1 <= int'(T)) ? 1 : 0) + ((!to0 && (w1 + 1 <= int'(T))) ? 1 : 0);

    @(negedge clock);
    start = 1'b1;
    slave_drive();
    @(negedge clock);
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_done_clr", done, 1'b0);
    check("start_idok_clr", id_ok, 1'b0);
    check("start_tsok_clr", ts_ok, 1'b0);
    check("start_tmo_clr", timeout, 1'b0);

    bcnt = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy) bcnt++;
      slave_drive();
      @(negedge clock);
    end
    start = 1'b0;

    if (!to0) m_id = d0;
    if (!to0 && !to1) m_ts = d1;
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_av_read", av_read, 1'b0);
    check("busy_cycles", bcnt, cyc);
    check("accepts", accepts, acc);
    check("id_ok", id_ok, !to0 && (d0 == EID));
    check("ts_ok", ts_ok, !to0 && !to1 && (d1 == ETS));
    check("timeout", timeout, to0 || to1);
    check("id_value", id_value, m_id);
    check("ts_value", ts_value, m_ts);

    repeat (2) begin
      slave_drive();
      @(negedge clock);
    end
    check("hold_done", done, 1'b1);
    check("hold_id_value", id_value, m_id);
    check("hold_ts_value", ts_value, m_ts);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_av_read"}, av_read, 1'b0);
    check({tag, "_av_address"}, av_address, 1'b0);
    check({tag, "_id_ok"}, id_ok, 1'b0);
    check({tag, "_ts_ok"}, ts_ok, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_id_value"}, id_value, 32'h0);
    check({tag, "_ts_value"}, ts_value, 32'h0);
  endtask

  function automatic int rnd_w();
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(5, 11)) : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rnd_d(input logic [31:0] e);
    return ($urandom_range(0, 1) == 1) ? e : 32'($urandom);
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0;
    av_waitrequest = 1'b1; av_readdatavalid = 1'b0; av_readdata = '0;
    m_id = '0; m_ts = '0;
    cfg_wait = '{0, 0}; cfg_lat = '{0, 0}; cfg_data = '{EID, ETS}; cfg_never = '{0, 0};
    s_in_req = 1'b0; s_pend = 1'b0; accepts = 0;
    repeat (2) @(negedge clock);
    check_reset_outputs("por");
    reset_n = 1'b1;
    repeat (3) begin
      slave_drive();
      @(negedge clock);
    end
    check("idle_no_start_busy", busy, 1'b0);
    check("idle_stray_id", id_value, 32'h0);

    run_seq(0, 0, EID, 0, 0, 0, ETS, 0, 0);            // zero-wait slave
    run_seq(3, 2, 32'h124, 0, 0, 0, ETS, 0, 0);        // stalled, late ID mismatch
    run_seq(0, 0, EID, 0, 0, 0, ETS, 1, 0);            // timestamp never returns
    run_seq(1, 1, EID, 0, 2, 1, ETS, 0, 1);            // start pulses while busy
    run_seq(4, 5, EID, 0, 4, 6, ETS, 0, 0);            // ID at exactly T, TS at T+1
    run_seq(10, 0, EID, 0, 0, 0, ETS, 0, 0);           // stall past T before accept
    run_seq(9, 0, 32'hdead_beef, 0, 2, 3, 32'h5, 0, 0); // accept on last cycle
    run_seq(0, 0, EID, 0, 0, 0, ETS, 0, 0);            // re-run from FIN

    for (int k = 0; k < 12; k++) begin
      run_seq(rnd_w(), int'($urandom_range(0, 4)), rnd_d(EID), $urandom_range(0, 7) == 0,
              rnd_w(), int'($urandom_range(0, 4)), rnd_d(ETS), $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of ID_WAIT.
    cfg_wait = '{0, 0}; cfg_lat = '{6, 0}; cfg_data = '{EID, ETS}; cfg_never = '{0, 0};
    s_pend = 1'b0; s_in_req = 1'b0;
    @(negedge clock);
    start = 1'b1;
    slave_drive();
    @(negedge clock);
    start = 1'b0;
    slave_drive();
    @(negedge clock);
    check("pre_reset_busy", busy, 1'b1);
    slave_drive();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    s_pend = 1'b0; s_in_req = 1'b0;
    m_id = '0; m_ts = '0;
    repeat (3) begin
      slave_drive();
      @(negedge clock);
    end
    check("post_reset_idle_busy", busy, 1'b0);
    check("post_reset_idle_done", done, 1'b0);
    run_seq(0, 1, EID, 0, 1, 0, ETS, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
